// File: rtl/lisa_uart_rx_fifo.sv
// lisa_uart_rx_fifo: oversampled UART receiver with optional parity and a show-ahead receive FIFO
module lisa_uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          baud_ref,
  input  logic                          rxd,
  input  logic                          rd,
  output logic [DATA_BITS-1:0]          d,
  output logic                          data_avail,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          clr_err
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic ODD = PARITY_ODD != 0;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
  state_t state;
  logic rx_s1, rxs, rxs_q;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] sh;
  logic par_bad;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic at_lim, samp, stop_samp, push, pop_ok, push_ok;
  assign at_lim = tick_cnt == (state == START ? HALF : LAST);
  assign samp = baud_ref && at_lim;
  assign stop_samp = state == STOP && samp;
  assign push = stop_samp && rxs && !par_bad;
  assign pop_ok = rd && count != '0;
  assign push_ok = push && (count != FULL || pop_ok);
  assign d = mem[rd_ptr];
  assign data_avail = count != '0;
  // rxs_q is a third stage used only for falling-edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rx_s1, rxs, rxs_q} <= '1;
    else {rx_s1, rxs, rxs_q} <= {rxd, rx_s1, rxs};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      par_bad  <= 1'b0;
    end else begin
      if (state == IDLE) tick_cnt <= '0;
      else if (baud_ref) tick_cnt <= at_lim ? '0 : tick_cnt + 1'b1;
      case (state)
        IDLE: if (rxs_q && !rxs) state <= START;
        START: if (samp) begin
          state   <= rxs ? IDLE : DATA;
          bit_cnt <= '0;
          par_bad <= 1'b0;
        end
        DATA: if (samp) begin
          sh      <= {rxs, sh[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state <= PARITY_EN != 0 ? PARITY : STOP;
        end
        PARITY: if (samp) begin
          par_bad <= ^sh ^ rxs ^ ODD;
          state   <= STOP;
        end
        STOP: if (samp) state <= rxs ? IDLE : BRK;
        BRK: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) mem[wr_ptr] <= sh;
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      count  <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= (stop_samp && !rxs) || (frame_err && !clr_err);
      parity_err <= (stop_samp && rxs && par_bad) || (parity_err && !clr_err);
      overrun    <= (push && !push_ok) || (overrun && !clr_err);
    end
  end
endmodule

// File: tb/tb_lisa_uart_rx_fifo.sv
// tb_lisa_uart_rx_fifo: directed table-driven bench for the UART receiver FIFO
module tb_lisa_uart_rx_fifo;
  localparam int BIT = 64;
  typedef struct {
    logic snd;
    logic [7:0] tx;
    logic clr;
    logic rd;
    logic [7:0] ed;
    logic [2:0] ec;
    logic eo;
  } vec_t;
  logic clk = 0, rst_n = 0, rxd = 1, rxd2 = 1, rd = 0, clr_err = 0;
  logic rd2 = 0, clr2 = 0;
  logic [1:0] bcnt = 0;
  logic baud_ref;
  logic [7:0] d;
  logic [6:0] d2;
  logic [2:0] count, count2;
  logic data_avail, frame_err, parity_err, overrun;
  logic data_avail2, frame_err2, parity_err2, overrun2;
  int n_chk = 0, n_pass = 0;
  vec_t tbl [20];
  lisa_uart_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .baud_ref(baud_ref), .rxd(rxd), .rd(rd), .d(d),
    .data_avail(data_avail), .count(count), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun), .clr_err(clr_err)
  );
  lisa_uart_rx_fifo #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .baud_ref(baud_ref), .rxd(rxd2), .rd(rd2), .d(d2),
    .data_avail(data_avail2), .count(count2), .frame_err(frame_err2),
    .parity_err(parity_err2), .overrun(overrun2), .clr_err(clr2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) bcnt <= bcnt + 2'd1;
  assign baud_ref = bcnt == 2'd0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic drive(input bit two, input logic v);
    if (two) rxd2 = v;
    else rxd = v;
  endtask
  // frames start on a fixed baud_ref phase so sample edges are predictable
  task automatic send(input bit two, input logic [8:0] data, input int nb,
                      input bit has_par, input logic par, input logic stop);
    @(negedge clk);
    while (bcnt != 2'd3) @(negedge clk);
    drive(two, 1'b0);
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      drive(two, data[i]);
      repeat (BIT) @(negedge clk);
    end
    if (has_par) begin
      drive(two, par);
      repeat (BIT) @(negedge clk);
    end
    drive(two, stop);
    repeat (BIT) @(negedge clk);
  endtask
  task automatic pop();
    @(negedge clk) rd = 1;
    @(negedge clk) rd = 0;
  endtask
  task automatic clear();
    @(negedge clk) clr_err = 1;
    @(negedge clk) clr_err = 0;
  endtask
  initial begin
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b0};
    tbl[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h01, 3'd1, 1'b0};
    tbl[2]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h01, 3'd2, 1'b0};
    tbl[3]  = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h01, 3'd3, 1'b0};
    tbl[4]  = '{1'b1, 8'h04, 1'b0, 1'b0, 8'h01, 3'd4, 1'b0};
    tbl[5]  = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h01, 3'd4, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 3'd3, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 3'd2, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 3'd1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    for (int i = 0; i < 9; i++)
      tbl[11+i] = '{1'b1, 8'(8'h60 + i), 1'b0, 1'b1, 8'(8'h60 + i), 3'd1, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset d", 32'(d), 0);
    chk("reset data_avail", 32'(data_avail), 0);
    chk("reset count", 32'(count), 0);
    chk("reset errs", 32'({frame_err, parity_err, overrun}), 0);
    chk("reset count2", 32'(count2), 0);
    rst_n = 1;
    repeat (10) @(negedge clk);
    for (int r = 0; r < 20; r++) begin
      if (tbl[r].snd) send(0, {1'b0, tbl[r].tx}, 8, 0, 1'b0, 1'b1);
      if (tbl[r].clr) clear();
      repeat (2) @(negedge clk);
      chk($sformatf("row%0d count", r), 32'(count), 32'(tbl[r].ec));
      chk($sformatf("row%0d data_avail", r), 32'(data_avail), 32'(tbl[r].ec != 0));
      chk($sformatf("row%0d overrun", r), 32'(overrun), 32'(tbl[r].eo));
      if (tbl[r].ec != 0) chk($sformatf("row%0d d", r), 32'(d), 32'(tbl[r].ed));
      if (tbl[r].rd) pop();
    end
    // full FIFO: rd lands on the stop-sample edge, 609 clocks after the frame's first edge
    for (int i = 0; i < 4; i++) send(0, 9'(8'h40 + i), 8, 0, 1'b0, 1'b1);
    chk("full count", 32'(count), 4);
    fork
      send(0, 9'h44, 8, 0, 1'b0, 1'b1);
      begin
        @(negedge clk);
        while (bcnt != 2'd3) @(negedge clk);
        repeat (609) @(posedge clk);
        @(negedge clk) rd = 1;
        @(negedge clk) rd = 0;
      end
    join
    chk("simul count", 32'(count), 4);
    chk("simul overrun", 32'(overrun), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("simul drain%0d", i), 32'(d), 32'(8'h41 + i));
      pop();
    end
    chk("drained count", 32'(count), 0);
    send(0, 9'h81, 8, 0, 1'b0, 1'b0);
    repeat (30 * BIT) @(negedge clk);
    rxd = 1;
    repeat (20) @(negedge clk);
    chk("break frame_err", 32'(frame_err), 1);
    chk("break count", 32'(count), 0);
    clear();
    chk("clr frame_err", 32'(frame_err), 0);
    send(0, 9'h3C, 8, 0, 1'b0, 1'b1);
    chk("after break d", 32'(d), 32'h3C);
    chk("after break count", 32'(count), 1);
    chk("after break frame_err", 32'(frame_err), 0);
    pop();
    @(negedge clk) rxd = 0;
    repeat (8) @(negedge clk);
    rxd = 1;
    repeat (200) @(negedge clk);
    chk("glitch count", 32'(count), 0);
    chk("glitch frame_err", 32'(frame_err), 0);
    send(1, 9'h55, 7, 1, 1'b1, 1'b1);
    chk("parity good d2", 32'(d2), 32'h55);
    chk("parity good count2", 32'(count2), 1);
    chk("parity good err", 32'(parity_err2), 0);
    send(1, 9'h55, 7, 1, 1'b0, 1'b1);
    chk("parity bad err", 32'(parity_err2), 1);
    chk("parity bad count2", 32'(count2), 1);
    send(0, 9'h77, 8, 0, 1'b0, 1'b1);
    chk("pre-reset count", 32'(count), 1);
    fork
      send(0, 9'hFF, 8, 0, 1'b0, 1'b1);
      begin
        repeat (200) @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("midreset d", 32'(d), 0);
        chk("midreset count", 32'(count), 0);
        chk("midreset data_avail", 32'(data_avail), 0);
        chk("midreset errs", 32'({frame_err, parity_err, overrun}), 0);
        chk("midreset dut2", 32'({count2, parity_err2}), 0);
        rst_n = 1;
      end
    join
    repeat (20) @(negedge clk);
    chk("post-reset count", 32'(count), 0);
    chk("post-reset errs", 32'({frame_err, parity_err, overrun}), 0);
    send(0, 9'h12, 8, 0, 1'b0, 1'b1);
    chk("post-reset d", 32'(d), 32'h12);
    chk("post-reset count1", 32'(count), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
